// File: rtl/wb_mem_if.sv
// Wishbone classic bus bundle between a master and the wb_mem_responder slave.
// Signal suffixes (_i/_o) are named from the slave's point of view.
interface wb_mem_if;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_we_i;
    logic [31:0] wb_addr_i;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic        wb_err_o;

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_addr_i, wb_dat_i, wb_sel_i,
        output wb_dat_o, wb_ack_o, wb_err_o
    );

    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_addr_i, wb_dat_i, wb_sel_i,
        input  wb_dat_o, wb_ack_o, wb_err_o
    );
endinterface

// File: rtl/wb_mem_responder.sv
// Wishbone B3 classic slave RAM: byte-lane writes, WAIT_STATES wait cycles, one-cycle ack.
// Define WB_MEM_ERR_EN to answer out-of-window addresses with wb_err_o instead of aliasing.
module wb_mem_responder #(
    parameter int          ADDR_WIDTH  = 10,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic    wb_clk,
    input  logic    wb_rst,
    wb_mem_if.slave wb
);
    localparam int                    DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] BASE_IDX  = BASE_ADDR[ADDR_WIDTH+1:2];
    localparam logic [3:0]            WAIT_INIT = 4'(WAIT_STATES);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

    state_e                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic                  oor_q, oor_d;
    logic                  we_q, we_d;
    logic [31:0]           wdat_q, wdat_d;
    logic [3:0]            sel_q, sel_d;
    logic                  ack_q, ack_d;
    logic [31:0]           rdat_q, rdat_d;
    logic                  err_d;

    logic [31:0]           mem [DEPTH];

    logic                  req;
    logic                  req_oor;
    logic [ADDR_WIDTH-1:0] req_idx;
    logic                  commit;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] eff_idx;
    logic                  eff_oor;
    logic                  eff_we;
    logic [31:0]           eff_dat;
    logic [3:0]            eff_sel;

    assign req     = wb.wb_cyc_i & wb.wb_stb_i;
    assign req_idx = wb.wb_addr_i[ADDR_WIDTH+1:2] - BASE_IDX;

`ifdef WB_MEM_ERR_EN
    logic [31:0] req_off;
    logic        err_q;

    assign req_off = wb.wb_addr_i - BASE_ADDR;
    assign req_oor = (req_off >> (ADDR_WIDTH + 2)) != 32'd0;

    always_ff @(posedge wb_clk) begin
        if (wb_rst) err_q <= 1'b0;
        else        err_q <= err_d;
    end

    assign wb.wb_err_o = err_q;
`else
    logic unused_addr;

    assign req_oor     = 1'b0;
    assign unused_addr = ^{wb.wb_addr_i[31:ADDR_WIDTH+2], wb.wb_addr_i[1:0], err_d};
    assign wb.wb_err_o = 1'b0;
`endif

    // With zero wait states the commit happens on the sampling edge, so IDLE uses live inputs.
    always_comb begin
        if (state_q == S_IDLE) begin
            eff_idx = req_idx;
            eff_oor = req_oor;
            eff_we  = wb.wb_we_i;
            eff_dat = wb.wb_dat_i;
            eff_sel = wb.wb_sel_i;
        end else begin
            eff_idx = idx_q;
            eff_oor = oor_q;
            eff_we  = we_q;
            eff_dat = wdat_q;
            eff_sel = sel_q;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no latch is inferred.
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        oor_d   = oor_q;
        we_d    = we_q;
        wdat_d  = wdat_q;
        sel_d   = sel_q;
        rdat_d  = rdat_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        commit  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    idx_d  = req_idx;
                    oor_d  = req_oor;
                    we_d   = wb.wb_we_i;
                    wdat_d = wb.wb_dat_i;
                    sel_d  = wb.wb_sel_i;
                    cnt_d  = WAIT_INIT;
                    if (WAIT_STATES == 0) begin
                        state_d = S_RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (!wb.wb_cyc_i) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_d = S_RESP;
                        commit  = 1'b1;
                    end
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (commit) begin
            ack_d = ~eff_oor;
            err_d = eff_oor;
            if (eff_oor)      rdat_d = 32'd0;
            else if (!eff_we) rdat_d = mem[eff_idx];
        end
    end

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            oor_q   <= 1'b0;
            we_q    <= 1'b0;
            wdat_q  <= 32'd0;
            sel_q   <= 4'd0;
            ack_q   <= 1'b0;
            rdat_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            oor_q   <= oor_d;
            we_q    <= we_d;
            wdat_q  <= wdat_d;
            sel_q   <= sel_d;
            ack_q   <= ack_d;
            rdat_q  <= rdat_d;
        end
    end

    assign mem_we = commit & eff_we & ~eff_oor & ~wb_rst;

    // NOTE: the RAM array has no reset so it maps onto block RAM; only control state is reset.
    always_ff @(posedge wb_clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (eff_sel[b]) mem[eff_idx][8*b +: 8] <= eff_dat[8*b +: 8];
            end
        end
    end

    assign wb.wb_ack_o = ack_q;
    assign wb.wb_dat_o = rdat_q;
endmodule

// File: doc/wb_mem_responder.md
Name: wb_mem_responder

Overview:
- Wishbone classic (B3, non-pipelined) slave memory: the responder end of the bus that the control FSM drives for instruction fetch and LW/SW.
- Single-port 32-bit word RAM with byte-lane writes and a programmable number of wait states.
- Returns a registered single-cycle acknowledge.
- Serves as the instruction/data memory for the multicycle core in simulation and on FPGA.

Parameters:
- ADDR_WIDTH, 10, word-address bits; memory depth = 2^ADDR_WIDTH 32-bit words.
- WAIT_STATES, 1, extra cycles inserted before ack; legal range 0..15.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; used for the decode window.

Ports:
- wb_clk  in  1  clock; all logic on rising edge.
- wb_rst  in  1  synchronous, active-high reset.
- wb_cyc_i  in  1  bus cycle valid.
- wb_stb_i  in  1  strobe; a request exists when wb_cyc_i & wb_stb_i.
- wb_we_i  in  1  1 = write, 0 = read.
- wb_addr_i  in  32  byte address; bits [1:0] ignored.
- wb_dat_i  in  32  write data.
- wb_sel_i  in  4  byte enables; bit n covers bits [8n+7:8n].
- wb_dat_o  out  32  read data; valid in the ack cycle.
- wb_ack_o  out  1  transfer-complete pulse.
- wb_err_o  out  1  error pulse; tied 0 unless WB_MEM_ERR_EN is defined.

Behaviour:
- Reset values: wb_ack_o=0, wb_err_o=0, wb_dat_o=0, state=IDLE, wait counter=0, latched request registers=0. RAM contents are not reset.
- Word index = wb_addr_i[ADDR_WIDTH+1:2] - BASE_ADDR[ADDR_WIDTH+1:2], truncated to ADDR_WIDTH bits (wraps modulo depth).
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - On an edge with cyc&stb=1: latch addr, we, dat, sel and load wait counter with WAIT_STATES.
  - Go to WAIT if WAIT_STATES>0, else go to RESP.
- WAIT:
  - Decrement counter each edge; go to RESP on the edge where counter==1.
  - If wb_cyc_i=0 on any WAIT edge: abort to IDLE; no write, no ack.
- Entering RESP (one edge):
  - Write: commit latched bytes where latched sel=1; other bytes unchanged. sel=4'b0000 writes nothing but still acks. wb_dat_o keeps its previous value.
  - Read: wb_dat_o <= RAM[index]. sel is ignored; the full word is always returned.
  - wb_ack_o <= 1.
- RESP:
  - wb_ack_o high for exactly one cycle; next edge always returns to IDLE and clears ack.
  - wb_dat_o holds the last read value until the next read completes.
- Latency: ack is high in cycle N+WAIT_STATES+1, where N is the cycle in which the request is first sampled.
- Back-to-back: the earliest next request is sampled in the IDLE cycle after RESP. A master holding stb high after ack is treated as a new request.
- Request inputs change while in WAIT: ignored. Latched values are used.
- Reset asserted in any state: next state IDLE, ack/err forced 0, in-flight write dropped.
- wb_ack_o and wb_err_o are never both high.

Optional Feature:
- Macro: WB_MEM_ERR_EN.
- Defined: a request whose byte address is outside [BASE_ADDR, BASE_ADDR + 4*2^ADDR_WIDTH) follows the same FSM timing. In RESP it drives wb_err_o=1 instead of wb_ack_o, performs no write, and sets wb_dat_o=0.
- Undefined: no range check; out-of-range addresses alias modulo depth; wb_err_o is constant 0.

Test Plan:
- Reset: hold wb_rst 2 cycles with cyc/stb=1 -> ack=0, err=0, dat_o=0; first ack appears only after reset is released.
- WAIT_STATES=1:
  - Write addr 0x10, data 0xDEADBEEF, sel 4'hF; stb sampled cycle 0 -> ack in cycle 2 only.
  - Then read 0x10 -> dat_o=0xDEADBEEF with ack in cycle 2 of that request.
- Byte lanes: word 0x20 = 0x11223344; write 0xAABBCCDD with sel 4'b0101 -> readback 0x11BB33DD. Write with sel 0 -> value unchanged, ack still pulses.
- Abort: WAIT_STATES=3, write 0x55 to 0x30; drop cyc during WAIT -> no ack; readback of 0x30 shows the old value.
- Back-to-back, WAIT_STATES=0: stb held high across 3 reads of 0x0/0x4/0x8 -> ack pulses exactly every 2 cycles with the correct data each time.
- WB_MEM_ERR_EN defined, ADDR_WIDTH=10: write to 0x1000 -> err pulse, no ack, word 0 unchanged. Without the macro, the same access acks and overwrites word 0.
